// File: rtl/proc_pkg.sv
// Shared types for the basic processor control path.
// Opcode and sequencer state encodings.
package proc_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        LOAD  = 3'd0,
        STORE = 3'd1,
        ADD   = 3'd2,
        SUB   = 3'd3,
        BNE   = 3'd4,
        HALT  = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_READ   = 3'd3,
        S_EXEC   = 3'd4,
        S_WRITE  = 3'd5,
        S_HALT   = 3'd6
    } state_t;

endpackage

// File: rtl/sequencer.sv
// Fetch/decode/execute control FSM for the basic processor.
// Outputs decode combinationally from state, opcode, zero flag and mem_ready.
module sequencer
    import proc_pkg::*;
(
    input  logic            clock,
    input  logic            n_reset,
    input  logic [OP_W-1:0] op,
    input  logic            z_flag,
    input  logic            mem_ready,
    output logic            load_REG,
    output logic            ALU_REG,
    output logic            ALU_add,
    output logic            ALU_sub,
    output logic            load_IR,
    output logic            inc_PC,
    output logic            load_PC,
    output logic            load_MAR,
    output logic            load_MDR,
    output logic            sel_PC,
    output logic            CS,
    output logic            R_NW,
    output logic            halted
);

    state_t state;
    state_t next;

    // State register; reset parks the machine in idle.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) state <= S_IDLE;
        else          state <= next;
    end

    // Next-state and control strobe decode.
    always_comb begin
        next     = state;
        load_REG = 1'b0;
        ALU_REG  = 1'b0;
        ALU_add  = 1'b0;
        ALU_sub  = 1'b0;
        load_IR  = 1'b0;
        inc_PC   = 1'b0;
        load_PC  = 1'b0;
        load_MAR = 1'b0;
        load_MDR = 1'b0;
        sel_PC   = 1'b0;
        CS       = 1'b0;
        R_NW     = 1'b0;
        halted   = 1'b0;
        case (state)
            S_IDLE: next = S_FETCH;
            S_FETCH: begin
                CS     = 1'b1;
                R_NW   = 1'b1;
                sel_PC = 1'b1;
                if (mem_ready) begin
                    load_IR = 1'b1;
                    inc_PC  = 1'b1;
                    next    = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode_t'(op))
                    LOAD, ADD, SUB: begin
                        load_MAR = 1'b1;
                        next     = S_READ;
                    end
                    STORE: begin
                        load_MAR = 1'b1;
                        next     = S_WRITE;
                    end
                    BNE: begin
                        load_PC = ~z_flag;
                        next    = S_FETCH;
                    end
                    HALT:    next = S_HALT;
                    default: next = S_FETCH;
                endcase
            end
            S_READ: begin
                CS   = 1'b1;
                R_NW = 1'b1;
                if (mem_ready) begin
                    load_MDR = 1'b1;
                    next     = S_EXEC;
                end
            end
            S_EXEC: begin
                load_REG = 1'b1;
                // Only ADD/SUB route the ALU result; LOAD takes memory data directly.
                if (opcode_t'(op) == ADD) begin
                    ALU_REG = 1'b1;
                    ALU_add = 1'b1;
                end else if (opcode_t'(op) == SUB) begin
                    ALU_REG = 1'b1;
                    ALU_sub = 1'b1;
                end
                next = S_FETCH;
            end
            S_WRITE: begin
                CS = 1'b1;
                if (mem_ready) next = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            default: next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sequencer.sv
// Directed bench for the sequencer with an expected-strobe scoreboard.
// A small accumulator model consumes the control strobes.
module tb_sequencer;
    import proc_pkg::*;

    logic            clock;
    logic            n_reset;
    logic [OP_W-1:0] op;
    logic            z_flag;
    logic            mem_ready;
    logic load_REG, ALU_REG, ALU_add, ALU_sub, load_IR, inc_PC, load_PC;
    logic load_MAR, load_MDR, sel_PC, CS, R_NW, halted;

    localparam logic [12:0] B_REG  = 13'h1000;
    localparam logic [12:0] B_AREG = 13'h0800;
    localparam logic [12:0] B_ADD  = 13'h0400;
    localparam logic [12:0] B_SUB  = 13'h0200;
    localparam logic [12:0] B_IR   = 13'h0100;
    localparam logic [12:0] B_INC  = 13'h0080;
    localparam logic [12:0] B_LPC  = 13'h0040;
    localparam logic [12:0] B_MAR  = 13'h0020;
    localparam logic [12:0] B_MDR  = 13'h0010;
    localparam logic [12:0] B_SEL  = 13'h0008;
    localparam logic [12:0] B_CS   = 13'h0004;
    localparam logic [12:0] B_RNW  = 13'h0002;
    localparam logic [12:0] B_HLT  = 13'h0001;

    localparam logic [12:0] E_IDLE  = 13'h0000;
    localparam logic [12:0] E_FWAIT = B_SEL | B_CS | B_RNW;
    localparam logic [12:0] E_FETCH = E_FWAIT | B_IR | B_INC;
    localparam logic [12:0] E_RWAIT = B_CS | B_RNW;
    localparam logic [12:0] E_READ  = E_RWAIT | B_MDR;
    localparam logic [12:0] E_LD    = B_REG;
    localparam logic [12:0] E_ADD   = B_REG | B_AREG | B_ADD;
    localparam logic [12:0] E_SUB   = B_REG | B_AREG | B_SUB;
    localparam logic [12:0] E_WRITE = B_CS;

    logic [12:0] obs;
    logic [7:0]  mem_data;
    logic [7:0]  mdr;
    logic [7:0]  acc;
    logic [12:0] expq[$];
    int n_checks;
    int n_fail;

    assign obs = {load_REG, ALU_REG, ALU_add, ALU_sub, load_IR, inc_PC,
                  load_PC, load_MAR, load_MDR, sel_PC, CS, R_NW, halted};

    sequencer dut (
        .clock     (clock),
        .n_reset   (n_reset),
        .op        (op),
        .z_flag    (z_flag),
        .mem_ready (mem_ready),
        .load_REG  (load_REG),
        .ALU_REG   (ALU_REG),
        .ALU_add   (ALU_add),
        .ALU_sub   (ALU_sub),
        .load_IR   (load_IR),
        .inc_PC    (inc_PC),
        .load_PC   (load_PC),
        .load_MAR  (load_MAR),
        .load_MDR  (load_MDR),
        .sel_PC    (sel_PC),
        .CS        (CS),
        .R_NW      (R_NW),
        .halted    (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Datapath model: MDR and accumulator driven by the sequencer strobes.
    always @(posedge clock) begin
        if (load_MDR) mdr <= mem_data;
        if (load_REG) begin
            if (!ALU_REG)    acc <= mdr;
            else if (ALU_add) acc <= acc + mdr;
            else if (ALU_sub) acc <= acc - mdr;
        end
    end

    task automatic check(input string tag, input logic [12:0] act,
                         input logic [12:0] exp);
        n_checks++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, queue the expected strobes, compare at negedge.
    task automatic step(input logic [2:0] o, input logic z, input logic r,
                        input logic [12:0] exp, input string tag);
        logic [12:0] e;
        op = o;
        z_flag = z;
        mem_ready = r;
        expq.push_back(exp);
        @(negedge clock);
        e = expq.pop_front();
        check(tag, obs, e);
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        n_reset = 1'b0;
        op = 3'd0;
        z_flag = 1'b0;
        mem_ready = 1'b1;
        mem_data = 8'd5;
        mdr = 8'd0;
        acc = 8'd0;
        @(posedge clock);
        #1;
        step(3'd0, 1'b0, 1'b1, E_IDLE, "reset_hold");
        n_reset = 1'b1;

        // LOAD 5
        step(3'd0, 1'b0, 1'b1, E_IDLE,  "ld_idle");
        step(3'd0, 1'b0, 1'b1, E_FETCH, "ld_fetch");
        step(3'd0, 1'b0, 1'b1, B_MAR,   "ld_decode");
        step(3'd0, 1'b0, 1'b1, E_READ,  "ld_read");
        step(3'd0, 1'b0, 1'b1, E_LD,    "ld_exec");
        check("acc_load", {5'd0, acc}, 13'd5);

        // ADD 3 with one fetch wait state
        mem_data = 8'd3;
        step(3'd2, 1'b0, 1'b0, E_FWAIT, "add_fwait");
        step(3'd2, 1'b0, 1'b1, E_FETCH, "add_fetch");
        step(3'd2, 1'b0, 1'b1, B_MAR,   "add_decode");
        step(3'd2, 1'b0, 1'b1, E_READ,  "add_read");
        step(3'd2, 1'b0, 1'b1, E_ADD,   "add_exec");
        check("acc_add", {5'd0, acc}, 13'd8);

        // SUB 8
        mem_data = 8'd8;
        step(3'd3, 1'b0, 1'b1, E_FETCH, "sub_fetch");
        step(3'd3, 1'b0, 1'b1, B_MAR,   "sub_decode");
        step(3'd3, 1'b0, 1'b1, E_READ,  "sub_read");
        step(3'd3, 1'b0, 1'b1, E_SUB,   "sub_exec");
        check("acc_sub", {5'd0, acc}, 13'd0);

        // BNE taken, then not taken with the zero accumulator
        step(3'd4, 1'b0, 1'b1, E_FETCH, "bne0_fetch");
        step(3'd4, 1'b0, 1'b1, B_LPC,   "bne0_decode");
        step(3'd4, 1'b1, 1'b1, E_FETCH, "bne1_fetch");
        step(3'd4, (acc == 8'd0), 1'b1, E_IDLE, "bne1_decode");

        // NOP
        step(3'd5, 1'b0, 1'b1, E_FETCH, "nop_fetch");
        step(3'd5, 1'b0, 1'b1, E_IDLE,  "nop_decode");

        // STORE with three write wait states
        step(3'd1, 1'b0, 1'b1, E_FETCH, "st_fetch");
        step(3'd1, 1'b0, 1'b1, B_MAR,   "st_decode");
        step(3'd1, 1'b0, 1'b0, E_WRITE, "st_wait1");
        step(3'd1, 1'b0, 1'b0, E_WRITE, "st_wait2");
        step(3'd1, 1'b0, 1'b0, E_WRITE, "st_wait3");
        step(3'd1, 1'b0, 1'b1, E_WRITE, "st_done");

        // Reset while waiting in READ
        step(3'd0, 1'b0, 1'b1, E_FETCH, "rst_fetch");
        step(3'd0, 1'b0, 1'b1, B_MAR,   "rst_decode");
        step(3'd0, 1'b0, 1'b0, E_RWAIT, "rst_rwait");
        n_reset = 1'b0;
        #1;
        check("rst_async", obs, E_IDLE);
        @(posedge clock);
        #1;
        step(3'd0, 1'b0, 1'b1, E_IDLE, "rst_low");
        n_reset = 1'b1;
        step(3'd0, 1'b0, 1'b1, E_IDLE,  "rst_idle");
        step(3'd0, 1'b0, 1'b1, E_FETCH, "rst_refetch");

        // HALT: stuck with only halted high
        step(3'd7, 1'b0, 1'b1, E_IDLE, "halt_decode");
        for (int i = 0; i < 20; i++)
            step(3'd7, i[1], i[0], B_HLT, "halt_hold");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
